// File: rtl/meas_pkg.sv
// Shared types and defaults for the measurement sequencer.
// The control outputs are decoded from a state so they can be registered against the next state.
package meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ALIGN,
        ST_GATE,
        ST_LATCH,
        ST_HOLD
    } state_e;

    localparam int GL0_DEF = 1;
    localparam int GL1_DEF = 10;
    localparam int GL2_DEF = 100;
    localparam int GL3_DEF = 1000;

    typedef struct packed {
        logic cnt_clr;
        logic gate_en;
        logic latch;
        logic res_valid;
        logic busy;
    } ctl_t;

    function automatic ctl_t decode_ctl(state_e s);
        ctl_t c;
        c = '0;
        c.busy = (s != ST_IDLE);
        case (s)
            ST_CLEAR: c.cnt_clr   = 1'b1;
            ST_GATE:  c.gate_en   = 1'b1;
            ST_LATCH: c.latch     = 1'b1;
            ST_HOLD:  c.res_valid = 1'b1;
            default:  ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/meas_gate_timer.sv
// Counts 1 kHz ticks while the gate is open and flags the tick that ends the gate.
// The count stops at len-1 so it never runs past the programmed gate length.
module meas_gate_timer #(
    parameter int TCNT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic              tick_i,
    input  logic [TCNT_W-1:0] len_i,
    output logic              term_o
);

    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              last_w;

    assign last_w = (tcnt_q == len_i - TCNT_W'(1));
    assign term_o = en_i & tick_i & last_w;

    always_comb begin
        tcnt_d = tcnt_q;
        if (clr_i)
            tcnt_d = '0;
        else if (en_i && tick_i && !last_w)
            tcnt_d = tcnt_q + TCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tcnt_q <= '0;
        else        tcnt_q <= tcnt_d;
    end

endmodule

// File: rtl/meas_seq.sv
// Measurement sequencer: clear, align to a 1 kHz tick, open the gate for N ms, latch, hold result.
// All outputs are registered from the next state, so no input reaches an output combinationally.
module meas_seq
    import meas_pkg::*;
#(
    parameter int TCNT_W = 10,
    parameter int GL0    = GL0_DEF,
    parameter int GL1    = GL1_DEF,
    parameter int GL2    = GL2_DEF,
    parameter int GL3    = GL3_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_1khz,
    input  logic [1:0]        gate_sel,
    input  logic              start,
    input  logic              cont,
    input  logic              abort,
    input  logic              res_ready,
    output logic              cnt_clr,
    output logic              gate_en,
    output logic              latch,
    output logic              res_valid,
    output logic              busy,
    output logic [TCNT_W-1:0] gate_ticks
);

    state_e            state_q, state_d;
    ctl_t              ctl_q;
    logic [TCNT_W-1:0] gate_ticks_q;
    logic [TCNT_W-1:0] gl_sel;
    logic              load_d;
    logic              term;

    always_comb begin
        gl_sel = TCNT_W'(GL0);
        case (gate_sel)
            2'b00: gl_sel = TCNT_W'(GL0);
            2'b01: gl_sel = TCNT_W'(GL1);
            2'b10: gl_sel = TCNT_W'(GL2);
            2'b11: gl_sel = TCNT_W'(GL3);
            default: ;
        endcase
    end

    meas_gate_timer #(
        .TCNT_W (TCNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == ST_CLEAR),
        .en_i   (state_q == ST_GATE),
        .tick_i (tick_1khz),
        .len_i  (gate_ticks_q),
        .term_o (term)
    );

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || cont) begin
                    state_d = ST_CLEAR;
                    load_d  = 1'b1;
                end
            end
            ST_CLEAR: state_d = ST_ALIGN;
            ST_ALIGN: if (tick_1khz) state_d = ST_GATE;
            ST_GATE:  if (term) state_d = ST_LATCH;
            ST_LATCH: state_d = ST_HOLD;
            ST_HOLD: begin
                if (res_ready) begin
                    if (cont) begin
                        state_d = ST_CLEAR;
                        load_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // abort beats every other input arriving in the same cycle
        if (abort) begin
            state_d = ST_IDLE;
            load_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ctl_q        <= '0;
            gate_ticks_q <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= decode_ctl(state_d);
            if (load_d) gate_ticks_q <= gl_sel;
        end
    end

    assign cnt_clr    = ctl_q.cnt_clr;
    assign gate_en    = ctl_q.gate_en;
    assign latch      = ctl_q.latch;
    assign res_valid  = ctl_q.res_valid;
    assign busy       = ctl_q.busy;
    assign gate_ticks = gate_ticks_q;

endmodule

// File: tb/tb_meas_seq.sv
// Scoreboarded bench for meas_seq: expected measurement records are predicted from tick timing.
module tb_meas_seq;

    localparam int P   = 13;
    localparam int BUD = 20000;

    logic       clk = 1'b0, rst_n = 1'b0, tick;
    logic       start = 1'b0, cont = 1'b0, abort = 1'b0, res_ready = 1'b0;
    logic [1:0] gate_sel = 2'b00;
    logic       cnt_clr, gate_en, latch, res_valid, busy;
    logic [9:0] gate_ticks;

    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        int clr;
        int gs;
        int gl;
        int lat;
        int gt;
    } rec_t;

    rec_t sb[$];

    meas_seq #(
        .TCNT_W (10), .GL0 (1), .GL1 (10), .GL2 (100), .GL3 (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick_1khz  (tick),
        .gate_sel   (gate_sel),
        .start      (start),
        .cont       (cont),
        .abort      (abort),
        .res_ready  (res_ready),
        .cnt_clr    (cnt_clr),
        .gate_en    (gate_en),
        .latch      (latch),
        .res_valid  (res_valid),
        .busy       (busy),
        .gate_ticks (gate_ticks)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tick = (cyc % P == 0);

    function automatic int gl_of(input int sel);
        case (sel)
            0: return 1;
            1: return 10;
            2: return 100;
            default: return 15;
        endcase
    endfunction

    // Request sampled in cycle s: clear next cycle, first tick from s+2 on opens the gate.
    function automatic rec_t predict(input int s, input int sel);
        rec_t r;
        int   t0, n;
        n  = gl_of(sel);
        t0 = s + 2;
        while (t0 % P != 0) t0++;
        r.clr = s + 1;
        r.gs  = t0 + 1;
        r.gl  = n * P;
        r.lat = t0 + n * P + 1;
        r.gt  = n;
        return r;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int what);
        case (what)
            0: return res_valid;
            1: return busy;
            default: return gate_en;
        endcase
    endfunction

    task automatic wait_for(input int what, input logic want, input int budget);
        int k;
        k = 0;
        while (sig(what) !== want && k < budget) begin
            step();
            k++;
        end
        check($sformatf("wait_sig%0d", what), int'(sig(what) === want), 1);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step();
    endtask

    // Monitor: rebuild each measurement from observed outputs and score it on the latch pulse.
    int   m_clr = -1, m_gs = -1, m_gl = 0;
    logic g_prev = 1'b0;
    rec_t m_exp;

    always @(negedge clk) begin
        if (cnt_clr === 1'b1) begin
            m_clr = cyc;
            m_gs  = -1;
            m_gl  = 0;
        end
        if (gate_en === 1'b1) begin
            if (!g_prev) m_gs = cyc;
            m_gl++;
        end
        g_prev = (gate_en === 1'b1);
        if (latch === 1'b1) begin
            check("latch_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                m_exp = sb.pop_front();
                check("clr_cycle", m_clr, m_exp.clr);
                check("gate_start", m_gs, m_exp.gs);
                check("gate_len", m_gl, m_exp.gl);
                check("latch_cycle", cyc, m_exp.lat);
                check("gate_ticks", int'(gate_ticks), m_exp.gt);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rec_t r;
        int   s, sel;

        repeat (3) step();
        check("rst_cnt_clr", cnt_clr, 0);
        check("rst_gate_en", gate_en, 0);
        check("rst_latch", latch, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_gate_ticks", int'(gate_ticks), 0);
        rst_n = 1'b1;
        step();

        // one-shot measurements with ignored start / gate_sel changes while busy
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, 20)) step();
            sel = (i < 4) ? i : int'($urandom_range(0, 3));
            gate_sel = 2'(sel);
            start = 1'b1;
            s = cyc;
            sb.push_back(predict(s, sel));
            step();
            start = 1'b0;
            wait_for(2, 1'b1, BUD);
            repeat ($urandom_range(0, 5)) step();
            start = 1'b1;
            gate_sel = 2'($urandom_range(0, 3));
            step();
            start = 1'b0;
            wait_for(0, 1'b1, BUD);
            repeat ($urandom_range(0, 5)) step();
            res_ready = 1'b1;
            step();
            res_ready = 1'b0;
            wait_for(1, 1'b0, 20);
        end

        // continuous mode, consumer always ready; gate_sel change picked up at HOLD->CLEAR
        gate_sel = 2'd2;
        cont = 1'b1;
        res_ready = 1'b1;
        s = cyc;
        r = predict(s, 2);
        sb.push_back(r);
        r = predict(r.lat + 1, 2);
        sb.push_back(r);
        wait_cyc(r.clr + 2);
        gate_sel = 2'd3;
        r = predict(r.lat + 1, 3);
        sb.push_back(r);
        wait_cyc(r.clr + 2);
        cont = 1'b0;
        wait_for(1, 1'b0, BUD);

        // continuous mode with the consumer stalled: the hold must persist
        res_ready = 1'b0;
        gate_sel = 2'd0;
        cont = 1'b1;
        s = cyc;
        sb.push_back(predict(s, 0));
        step();
        wait_for(0, 1'b1, BUD);
        for (int k = 0; k < 10 * P; k++) begin
            check("hold_res_valid", res_valid, 1);
            check("hold_gate_en", gate_en, 0);
            check("hold_cnt_clr", cnt_clr, 0);
            step();
        end
        cont = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        wait_for(1, 1'b0, 20);

        // abort on tick 37 of a 100-tick gate
        gate_sel = 2'd2;
        start = 1'b1;
        s = cyc;
        r = predict(s, 2);
        step();
        start = 1'b0;
        wait_cyc(r.gs - 1 + 37 * P);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort37_busy", busy, 0);
        check("abort37_gate_en", gate_en, 0);
        check("abort37_res_valid", res_valid, 0);
        repeat (3 * P) begin
            check("abort37_no_latch", latch, 0);
            step();
        end

        // abort together with the terminal tick
        gate_sel = 2'd0;
        start = 1'b1;
        s = cyc;
        r = predict(s, 0);
        step();
        start = 1'b0;
        wait_cyc(r.lat - 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_term_busy", busy, 0);
        check("abort_term_gate_en", gate_en, 0);
        repeat (2 * P) begin
            check("abort_term_no_latch", latch, 0);
            step();
        end

        // reset while holding a result, overriding abort and start
        gate_sel = 2'd1;
        start = 1'b1;
        s = cyc;
        sb.push_back(predict(s, 1));
        step();
        start = 1'b0;
        wait_for(0, 1'b1, BUD);
        step();
        step();
        rst_n = 1'b0;
        abort = 1'b1;
        start = 1'b1;
        step();
        rst_n = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        check("hold_rst_cnt_clr", cnt_clr, 0);
        check("hold_rst_gate_en", gate_en, 0);
        check("hold_rst_latch", latch, 0);
        check("hold_rst_res_valid", res_valid, 0);
        check("hold_rst_busy", busy, 0);
        check("hold_rst_gate_ticks", int'(gate_ticks), 0);
        step();
        check("post_rst_idle", busy, 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/meas_seq.md
MEAS_SEQ -- requirements
Module: meas_seq

Interface
REQ-001 SHALL have parameter TCNT_W, default 10: width of the gate tick counter and of gate_ticks.
REQ-002 SHALL have parameter GL0, default 1: gate length in ms for gate_sel=00.
REQ-003 SHALL have parameter GL1, default 10: gate length in ms for gate_sel=01.
REQ-004 SHALL have parameter GL2, default 100: gate length in ms for gate_sel=10.
REQ-005 SHALL have parameter GL3, default 1000: gate length in ms for gate_sel=11.
REQ-006 SHALL have port clk, in, 1: the single system clock (50 MHz); all logic on its rising edge.
REQ-007 SHALL have port rst_n, in, 1: synchronous, active-low reset.
REQ-008 SHALL have port tick_1khz, in, 1: one-cycle 1 kHz strobe, synchronous to clk.
REQ-009 SHALL have port gate_sel, in, 2: gate length select.
REQ-010 SHALL have port start, in, 1: one-shot measurement request.
REQ-011 SHALL have port cont, in, 1: continuous mode level.
REQ-012 SHALL have port abort, in, 1: cancel the measurement in progress.
REQ-013 SHALL have port res_ready, in, 1: the consumer accepts the result.
REQ-014 SHALL have port cnt_clr, out, 1: clear pulse to the phase/period counters.
REQ-015 SHALL have port gate_en, out, 1: counters count while this is high.
REQ-016 SHALL have port latch, out, 1: capture pulse for the counter results.
REQ-017 SHALL have port res_valid, out, 1: the result is held and valid.
REQ-018 SHALL have port busy, out, 1: high in every state except IDLE.
REQ-019 SHALL have port gate_ticks, out, TCNT_W: gate length of the current or last measurement, in ms.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, ALIGN, GATE, LATCH, HOLD; all outputs are Moore-decoded from registered state, with no input-to-output combinational path.
REQ-021 IDLE: if start or cont is sampled high, next state is CLEAR, and gate_ticks is loaded from GLx selected by gate_sel; otherwise the FSM stays in IDLE.
REQ-022 CLEAR: cnt_clr=1 for exactly one cycle; next state is ALIGN; the tick counter tcnt is zeroed.
REQ-023 ALIGN: wait for tick_1khz, then go to GATE, so the gate opens 1 cycle after a tick edge.
REQ-024 GATE: gate_en=1; each tick_1khz increments tcnt; a tick with tcnt==gate_ticks-1 moves to LATCH, so the gate is exactly gate_ticks×50000 clk cycles.
REQ-025 LATCH: latch=1 for one cycle; next state is HOLD.
REQ-026 HOLD: res_valid=1 until res_ready is high; then go to CLEAR if cont is high, otherwise to IDLE.
REQ-027 Whenever res_valid=1 and res_ready=0, the hold SHALL persist indefinitely and no new gate starts.
REQ-028 start while busy SHALL be ignored; a gate_sel change while busy SHALL be ignored until the next IDLE or HOLD→CLEAR load.
REQ-029 The HOLD→CLEAR transition SHALL reload gate_ticks from the current gate_sel.
REQ-030 abort SHALL force IDLE on the next edge from any state and drop gate_en, latch, and res_valid; it takes priority over tick, start, cont, and res_ready arriving in the same cycle.
REQ-031 tick_1khz in IDLE, CLEAR, LATCH, or HOLD SHALL have no effect; tcnt SHALL never exceed gate_ticks-1.
REQ-032 In CLEAR, tick_1khz SHALL NOT count; alignment always occurs in ALIGN.

Reset
REQ-033 On rst_n=0 at a clk edge: state=IDLE; cnt_clr, gate_en, latch, res_valid, busy = 0; tcnt=0; gate_ticks=0.
REQ-034 Reset in mid-measurement SHALL take effect at the next edge, identical to abort, and rst_n SHALL override abort.

Structure
REQ-035 The state enum and default gate-length constants SHALL live in shared package meas_pkg.
REQ-036 A single sub-module meas_gate_timer (tcnt, tick compare, terminal flag) is natural; the FSM stays in meas_seq.

Verification
REQ-037 gate_sel=00, start pulse: cnt_clr 1 cycle after start; gate_en high for exactly 50000 cycles; latch 1 cycle after gate_en falls; res_valid high until res_ready.
REQ-038 gate_sel=10, cont=1, res_ready tied 1: back-to-back measurements, each gate_en = 5,000,000 cycles; gate_ticks=100.
REQ-039 Abort in GATE at tick 37 of 100: next cycle busy=0, gate_en=0, and no latch pulse.
REQ-040 Abort and tick in the same cycle on the terminal tick: IDLE, no LATCH.
REQ-041 res_ready held 0 for 10 ms in cont mode: res_valid stays 1, gate_en stays 0, and no extra cnt_clr.
REQ-042 rst_n=0 asserted in HOLD: next edge all outputs 0; start while busy ignored.
